// File: rtl/dmem_line_responder.sv
// Fixed-latency off-chip data memory answering dcache line fills and write-backs.
// Optional DMEM_PROTOCOL_CHECK_EN adds a sticky err_o for requests that change while they are in flight.
module dmem_line_responder #(
    parameter int LATENCY = 10,
    parameter int LINE_AW = 9
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         enable_i,
    input  logic         write_i,
    input  logic [31:0]  addr_i,
    input  logic [255:0] data_i,
    output logic         ack_o,
    output logic [255:0] data_o,
    output logic         err_o
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_ACK  = 2'd2;
    localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 2);

    logic [1:0]         state_reg, state_next;
    logic [7:0]         cnt_reg, cnt_next;
    logic [LINE_AW-1:0] idx_reg;
    logic               wr_reg;
    logic [255:0]       wdata_reg;
    logic               ack_reg;
    logic [255:0]       rdata_reg;
    logic               err_reg;
    logic               accept;
    logic               complete;

    logic [255:0] mem [2**LINE_AW];

    // Byte offset and address bits above the array alias away.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr_i[31:LINE_AW+5], addr_i[4:0]};

    assign accept   = (state_reg == S_IDLE) && enable_i;
    assign complete = (state_reg == S_WAIT) && (cnt_reg == 8'd0);

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            S_IDLE: begin
                if (enable_i) begin
                    state_next = S_WAIT;
                    cnt_next   = CNT_LOAD;
                end
            end
            S_WAIT: begin
                if (cnt_reg == 8'd0) begin
                    state_next = S_ACK;
                end else begin
                    cnt_next = cnt_reg - 8'd1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_reg <= S_IDLE;
            cnt_reg   <= 8'd0;
            idx_reg   <= '0;
            wr_reg    <= 1'b0;
            wdata_reg <= '0;
            ack_reg   <= 1'b0;
            rdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            ack_reg   <= complete;
            if (accept) begin
                idx_reg   <= addr_i[LINE_AW+4:5];
                wr_reg    <= write_i;
                wdata_reg <= data_i;
            end
            if (complete && !wr_reg) begin
                rdata_reg <= mem[idx_reg];
            end
        end
    end

    // Array carries no reset; an aborted request never reaches the commit edge
    // because reset forces the FSM out of WAIT.
    always_ff @(posedge clk_i) begin
        if (complete && wr_reg) begin
            mem[idx_reg] <= wdata_reg;
        end
    end

`ifdef DMEM_PROTOCOL_CHECK_EN
    logic req_changed;

    always_comb begin
        req_changed = 1'b0;
        if (state_reg == S_WAIT) begin
            req_changed = !enable_i
                       || (write_i != wr_reg)
                       || (addr_i[LINE_AW+4:5] != idx_reg)
                       || (wr_reg && (data_i != wdata_reg));
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            err_reg <= 1'b0;
        end else if (req_changed) begin
            err_reg <= 1'b1;
        end
    end
`else
    assign err_reg = 1'b0;
`endif

    assign ack_o  = ack_reg;
    assign data_o = rdata_reg;
    assign err_o  = err_reg;
endmodule

// File: tb/tb_dmem_line_responder.sv
// Directed plus randomized checks of dmem_line_responder against a line-level memory model.
// Build with DMEM_PROTOCOL_CHECK_EN defined to expect the sticky err_o behaviour.
module tb_dmem_line_responder;
    localparam int LATENCY = 10;
    localparam int LINE_AW = 9;
`ifdef DMEM_PROTOCOL_CHECK_EN
    localparam bit ERR_ON = 1'b1;
`else
    localparam bit ERR_ON = 1'b0;
`endif

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         enable_i;
    logic         write_i;
    logic [31:0]  addr_i;
    logic [255:0] data_i;
    logic         ack_o;
    logic [255:0] data_o;
    logic         err_o;

    dmem_line_responder #(.LATENCY(LATENCY), .LINE_AW(LINE_AW)) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .enable_i (enable_i),
        .write_i  (write_i),
        .addr_i   (addr_i),
        .data_i   (data_i),
        .ack_o    (ack_o),
        .data_o   (data_o),
        .err_o    (err_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    // Reference model: whole lines keyed by line index, plus expected output state.
    logic [255:0] mem_m [int];
    logic [255:0] dout_exp = '0;
    logic         err_exp  = 1'b0;
    int n_cmp = 0;
    int n_err = 0;
    int last_ack = 0;
    int prev_ack = 0;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int line_of(input logic [31:0] a);
        return int'(a % 32'h4000) / 32;
    endfunction

    task automatic idle(input int n);
        @(negedge clk_i);
        enable_i = 1'b0;
        repeat (n) @(posedge clk_i);
    endtask

    // mode 0: hold request stable; 1: scramble inputs during WAIT; 2: move addr to 0x80 during WAIT
    task automatic do_req(input logic w, input logic [31:0] a, input logic [255:0] d, input int mode);
        int n;
        int idx;
        idx = line_of(a);
        @(negedge clk_i);
        enable_i = 1'b1;
        write_i  = w;
        addr_i   = a;
        data_i   = d;
        @(posedge clk_i);
        #1;
        n = 0;
        do begin
            @(posedge clk_i);
            #1;
            n++;
            if (!ack_o && mode == 1) begin
                enable_i = 1'b0;
                write_i  = 1'($urandom);
                addr_i   = $urandom;
                data_i   = {8{$urandom}};
            end
            if (mode == 2 && n == 2) addr_i = 32'h0000_0080;
            if (mode == 2 && n == 3) chk("err_after_addr_change", 256'(err_o), 256'(ERR_ON));
        end while (!ack_o && n < 300);
        chk("ack_latency", 256'(n), 256'(LATENCY - 1));
        if (w) mem_m[idx] = d;
        else   dout_exp = mem_m[idx];
        chk(w ? "data_o_after_write" : "data_o_after_read", data_o, dout_exp);
        if (mode != 0 && ERR_ON) err_exp = 1'b1;
        prev_ack = last_ack;
        last_ack = cyc;
        @(posedge clk_i);
        #1;
        chk("ack_single_pulse", 256'(ack_o), 256'(0));
        chk("err_o", 256'(err_o), 256'(err_exp));
    endtask

    logic [255:0] d0;
    logic [255:0] d_line3;
    logic [31:0]  a;
    logic         w;
    int           idx;

    initial begin
        rst_i = 1'b0;
        enable_i = 1'b0;
        write_i = 1'b0;
        addr_i = '0;
        data_i = '0;
        repeat (2) @(posedge clk_i);
        #1;
        chk("reset_ack", 256'(ack_o), 256'(0));
        chk("reset_data", data_o, '0);
        chk("reset_err", 256'(err_o), 256'(0));
        @(negedge clk_i);
        rst_i = 1'b1;

        // Preload line 2, then fill it
        do_req(1'b1, 32'h0000_0040, {32{8'hA5}}, 0);
        idle(2);
        do_req(1'b0, 32'h0000_0040, '0, 0);
        idle(1);

        // Write then read at the top of the byte range for this line
        do_req(1'b1, 32'h0000_1FE0, {4{64'h0123_4567_89AB_CDEF}}, 0);
        idle(1);
        do_req(1'b0, 32'h0000_1FE0, '0, 0);
        idle(2);

        // Write-back then fill, enable held high across the ack
        do_req(1'b1, 32'h0000_0800, {8{32'hFEED_0800}}, 0);
        idle(1);
        d0 = {8{$urandom}};
        do_req(1'b1, 32'h0000_0400, d0, 0);
        do_req(1'b0, 32'h0000_0800, '0, 0);
        chk("b2b_ack_spacing", 256'(last_ack - prev_ack), 256'(LATENCY + 1));
        idle(1);
        do_req(1'b0, 32'h0000_0400, '0, 0);
        idle(1);

        // Reset in the middle of a write to line 3 aborts it
        d_line3 = {8{32'h3333_CAFE}};
        do_req(1'b1, 32'h0000_0060, d_line3, 0);
        idle(1);
        @(negedge clk_i);
        enable_i = 1'b1;
        write_i  = 1'b1;
        addr_i   = 32'h0000_0060;
        data_i   = {8{32'hDEAD_BEEF}};
        @(posedge clk_i);
        repeat (5) @(posedge clk_i);
        #2;
        rst_i = 1'b0;
        #1;
        chk("midreset_ack", 256'(ack_o), 256'(0));
        chk("midreset_data", data_o, '0);
        chk("midreset_err", 256'(err_o), 256'(0));
        enable_i = 1'b0;
        repeat (LATENCY) @(posedge clk_i);
        #1;
        chk("midreset_no_ack", 256'(ack_o), 256'(0));
        @(negedge clk_i);
        rst_i = 1'b1;
        dout_exp = '0;
        err_exp  = 1'b0;
        idle(2);
        do_req(1'b0, 32'h0000_0060, '0, 0);
        idle(1);

        // Aliasing above the array size
        do_req(1'b1, 32'h0000_4020, {8{32'hA11A_5000}}, 0);
        idle(1);
        do_req(1'b0, 32'h0000_0020, '0, 0);
        idle(1);

        // Address moved during WAIT: data still from the latched line
        do_req(1'b0, 32'h0000_0040, '0, 2);
        chk("err_sticky", 256'(err_o), 256'(ERR_ON));
        idle(1);

        // Randomized traffic over a few lines with aliasing upper bits
        for (int i = 0; i < 16; i++) begin
            idx = int'($urandom_range(0, 7));
            a = ($urandom & 32'hFFFF_C000) | (32'(idx) << 5) | ($urandom & 32'h1F);
            w = (!mem_m.exists(idx)) ? 1'b1 : 1'($urandom_range(0, 1));
            do_req(w, a, {8{$urandom}}, ERR_ON ? 0 : int'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(0, 2)));
        end
        idle(2);
        chk("final_err", 256'(err_o), 256'(err_exp));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/dmem_line_responder.md
Name: dmem_line_responder

Overview:
- Off-chip data memory model that responds to the data cache's line-fill and write-back requests.
- Serves 256-bit (32-byte) lines over an enable/write/ack handshake: the cache holds a request stable until a single-cycle ack.
- Fixed, parameterised access latency.
- Sits between the dcache miss controller and the testbench/top level; it is the responder side of the cache memory interface.

Parameters:
- LATENCY, 10, cycles from request acceptance to ack; legal range 2..255.
- LINE_AW, 9, line-index width; memory holds 2**LINE_AW lines of 256 bits.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  reset, asynchronous, active-low.
- enable_i  input  1  request valid from the cache.
- write_i  input  1  1 = write line, 0 = read line.
- addr_i  input  32  byte address; bits [4:0] ignored; line index = addr_i[LINE_AW+4:5]; upper bits discarded, so addresses alias modulo the array size.
- data_i  input  256  write line data.
- ack_o  output  1  single-cycle completion pulse.
- data_o  output  256  read line data.
- err_o  output  1  sticky protocol-error flag; see Optional Feature.

Behaviour:
- Reset values: ack_o=0, data_o=0, err_o=0, state=IDLE, latency counter=0. The memory array is not cleared by reset.
- Reset asserted mid-request aborts the request: no array write, no ack. After reset release the block is in IDLE.
- States: IDLE, WAIT, ACK.
- IDLE:
  - If enable_i=1 at a rising edge, the request is accepted.
  - On acceptance: latch addr line index, write_i and data_i into internal registers; load the counter with LATENCY-2; go to WAIT.
  - Otherwise stay in IDLE.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter is 0, at the next edge:
    - For a write: commit the latched data to array[latched index].
    - For a read: load data_o with array[latched index].
    - Set ack_o=1 and go to ACK.
  - Inputs during WAIT are ignored; the latched values are used. Dropping enable_i does not cancel the request, which still completes and acks.
- ACK:
  - ack_o=1 for exactly this cycle. The next edge clears ack_o and returns to IDLE.
  - enable_i is not sampled in ACK. This matches the cache dropping or redirecting enable at the ack edge.
- Timing:
  - Request accepted at edge E (enable_i=1 in IDLE); ack_o is high during the cycle after edge E+LATENCY-1. Total latency from acceptance is exactly LATENCY cycles.
  - Back-to-back: if enable_i is still or again 1 in the IDLE cycle after ACK, the next request is accepted there. Accepted requests are separated by LATENCY+1 cycles.
  - Example: write-back then fill, with enable held high and write_i switched 1->0 at the ack edge.
- data_o:
  - Holds its value after ack until the next read completes.
  - A write does not change data_o.
- Read-after-write to the same line returns the newly written data: the commit occurs at the write's ack edge, before any later read can be accepted.
- Only one request is outstanding at a time; there is no queueing.

Optional Feature:
- Macro: DMEM_PROTOCOL_CHECK_EN.
- Defined:
  - In WAIT, compare live inputs against the latched request.
  - err_o is set if enable_i=0, write_i differs, addr_i[LINE_AW+4:5] differs, or (for a write) data_i differs.
  - err_o is sticky until reset; the request still completes normally.
- Undefined: the comparison logic is absent and err_o is tied to 0.

Test Plan:
- Reset, then read at line address 0x0000_0040 with the array preloaded to 256'hA5...A5 → ack_o is a single pulse exactly LATENCY=10 cycles after acceptance; data_o=256'hA5...A5; err_o=0.
- Write 256'h0123_..._CDEF to address 0x0000_1FE0, then read the same address → second ack returns 256'h0123_..._CDEF; data_o is unchanged by the write ack.
- Write-back to 0x0000_0400 followed by a fill from 0x0000_0800, with enable held high and write_i switched at the ack edge → second acceptance occurs in the IDLE cycle after ACK; second ack comes 11 cycles after the first; the 0x400 line holds the written data.
- Assert rst_i=0 in WAIT, cycle 5 of a write to 0x0000_0060 → ack never pulses, array[3] is unchanged, and all outputs return to reset values. A request after release completes normally.
- Address aliasing with LINE_AW=9: write to 0x0000_4020, read from 0x0000_0020 → the read returns the written data.
- With DMEM_PROTOCOL_CHECK_EN: change addr_i from 0x40 to 0x80 during WAIT → err_o=1 from the next cycle and stays set; the ack still comes with line 0x40's data. Without the macro, err_o stays 0.
